// File: rtl/board_pin_exerciser_pkg.sv
// Shared mode encodings and per-mode pattern seeds for the
// board bring-up pin exerciser.
package board_pin_exerciser_pkg;

    localparam logic [1:0] MODE_OFF    = 2'd0;
    localparam logic [1:0] MODE_COUNT  = 2'd1;
    localparam logic [1:0] MODE_WALK   = 2'd2;
    localparam logic [1:0] MODE_TOGGLE = 2'd3;

    // Only WALK seeds a non-zero pattern (bit 0 set); callers
    // zero-extend this to the pin bank width.
    function automatic logic seed_lsb(input logic [1:0] mode);
        return (mode == MODE_WALK);
    endfunction

endpackage

// File: rtl/board_pin_prescaler.sv
// Programmable tick prescaler: counts 0..div and pulses tick
// on the terminal count; clear restarts the period.
module board_pin_prescaler #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] presc_q;
    logic [DIV_W-1:0] presc_d;

    assign tick = (presc_q == div);

    always_comb begin
        presc_d = presc_q + 1'b1;
        if (clear || tick) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/board_pin_exerciser.sv
// Bring-up pattern generator: selectable pin pattern advanced
// by a prescaled tick, plus an independent heartbeat.
module board_pin_exerciser
    import board_pin_exerciser_pkg::*;
#(
    parameter int             NUM_PINS  = 32,
    parameter int             DIV_W     = 24,
    parameter logic [DIV_W-1:0] DIV_RESET = '0,
    parameter int             HB_BIT    = 23
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          mode_i,
    input  logic                mode_load_i,
    input  logic [DIV_W-1:0]    div_i,
    output logic [NUM_PINS-1:0] pins_o,
    output logic                tick_o,
    output logic [1:0]          mode_o,
    output logic                heartbeat_o
);

    logic [1:0]          mode_q;
    logic [DIV_W-1:0]    div_q;
    logic [NUM_PINS-1:0] pat_q;
    logic [NUM_PINS-1:0] pat_d;
    logic                tick_q;
    logic                tick;
    logic [31:0]         hb_q;
    logic [31:0]         hb_d;
    logic                hb_o_q;

    board_pin_prescaler #(
        .DIV_W (DIV_W)
    ) u_presc (
        .clk   (clk),
        .rst   (rst),
        .clear (mode_load_i),
        .div   (div_q),
        .tick  (tick)
    );

    // A load reseeds the pattern and wins over a coincident tick.
    always_comb begin
        pat_d = pat_q;
        if (mode_load_i) begin
            pat_d = NUM_PINS'(seed_lsb(mode_i));
        end else if (tick) begin
            unique case (mode_q)
                MODE_OFF:    pat_d = '0;
                MODE_COUNT:  pat_d = pat_q + 1'b1;
                MODE_WALK:   pat_d = {pat_q[NUM_PINS-2:0],
                                      pat_q[NUM_PINS-1]};
                MODE_TOGGLE: pat_d = ~pat_q;
            endcase
        end
    end

    assign hb_d = hb_q + 32'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_COUNT;
            div_q  <= DIV_RESET;
            pat_q  <= '0;
            tick_q <= 1'b0;
            hb_q   <= '0;
            hb_o_q <= 1'b0;
        end else begin
            if (mode_load_i) begin
                mode_q <= mode_i;
                div_q  <= div_i;
            end
            pat_q  <= pat_d;
            tick_q <= tick & ~mode_load_i;
            hb_q   <= hb_d;
            hb_o_q <= hb_d[HB_BIT];
        end
    end

    assign pins_o      = pat_q;
    assign tick_o      = tick_q;
    assign mode_o      = mode_q;
    assign heartbeat_o = hb_o_q;

endmodule

// File: tb/tb_board_pin_exerciser.sv
// Self-checking bench for board_pin_exerciser (8 pins, 4-bit
// divider, heartbeat on bit 3) against a tick-count model.
module tb_board_pin_exerciser;

    localparam int NP = 8;
    localparam int DW = 4;
    localparam int HB = 3;

    logic          clk;
    logic          rst;
    logic [1:0]    mode_i;
    logic          mode_load_i;
    logic [DW-1:0] div_i;
    logic [NP-1:0] pins_o;
    logic          tick_o;
    logic [1:0]    mode_o;
    logic          heartbeat_o;

    board_pin_exerciser #(
        .NUM_PINS  (NP),
        .DIV_W     (DW),
        .DIV_RESET ('0),
        .HB_BIT    (HB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode_i      (mode_i),
        .mode_load_i (mode_load_i),
        .div_i       (div_i),
        .pins_o      (pins_o),
        .tick_o      (tick_o),
        .mode_o      (mode_o),
        .heartbeat_o (heartbeat_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: pattern is a closed-form function of edges since the
    // last load (or reset) and the captured period.
    int m_mode;
    int m_div;
    int k;
    int n_edges;

    typedef struct {
        logic          ld;
        logic [1:0]    m;
        logic [DW-1:0] d;
        logic [NP-1:0] pins;
        logic          tick;
        logic [1:0]    mode;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    function automatic int exp_pins();
        int t;
        t = k / (m_div + 1);
        case (m_mode)
            1:       return t % 256;
            2:       return 1 << (t % 8);
            3:       return (t % 2 == 1) ? 255 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic int exp_tick();
        return (k != 0 && (k % (m_div + 1)) == 0) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_mode  = 1;
        m_div   = 0;
        k       = 0;
        n_edges = 0;
    endtask

    task automatic model_edge(input logic ld, input logic [1:0] m,
                              input logic [DW-1:0] d);
        n_edges++;
        if (ld) begin
            m_mode = int'(m);
            m_div  = int'(d);
            k      = 0;
        end else begin
            k++;
        end
    endtask

    task automatic check_all();
        chk("pins", 32'(pins_o), 32'(exp_pins()));
        chk("tick", 32'(tick_o), 32'(exp_tick()));
        chk("mode", 32'(mode_o), 32'(m_mode));
        chk("heartbeat", 32'(heartbeat_o),
            32'((n_edges >> HB) & 1));
        if (m_mode == 2) begin
            chk("walk_onehot", 32'($countones(pins_o)), 32'd1);
        end
    endtask

    task automatic cyc(input logic ld, input logic [1:0] m,
                       input logic [DW-1:0] d);
        mode_load_i = ld;
        mode_i      = m;
        div_i       = d;
        @(posedge clk);
        model_edge(ld, m, d);
        @(negedge clk);
        mode_load_i = 1'b0;
        check_all();
    endtask

    int cnt;
    logic saw_ff;

    initial begin
        clk         = 1'b0;
        rst         = 1'b1;
        mode_i      = 2'd0;
        mode_load_i = 1'b0;
        div_i       = '0;
        model_reset();

        tbl[0] = '{1'b0, 2'd0, 4'd0, 8'h01, 1'b1, 2'd1};
        tbl[1] = '{1'b0, 2'd0, 4'd0, 8'h02, 1'b1, 2'd1};
        tbl[2] = '{1'b0, 2'd0, 4'd0, 8'h03, 1'b1, 2'd1};
        tbl[3] = '{1'b1, 2'd2, 4'd2, 8'h01, 1'b0, 2'd2};
        tbl[4] = '{1'b0, 2'd0, 4'd0, 8'h01, 1'b0, 2'd2};
        tbl[5] = '{1'b0, 2'd0, 4'd0, 8'h01, 1'b0, 2'd2};
        tbl[6] = '{1'b0, 2'd0, 4'd0, 8'h02, 1'b1, 2'd2};

        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            cyc(tbl[i].ld, tbl[i].m, tbl[i].d);
            chk("tbl_pins", 32'(pins_o), 32'(tbl[i].pins));
            chk("tbl_tick", 32'(tick_o), 32'(tbl[i].tick));
            chk("tbl_mode", 32'(mode_o), 32'(tbl[i].mode));
        end
        repeat (30) cyc(1'b0, 2'd0, 4'd0);

        cyc(1'b1, 2'd3, 4'd0);
        chk("toggle_seed", 32'(pins_o), 32'h00);
        cyc(1'b0, 2'd0, 4'd0);
        chk("toggle_ff", 32'(pins_o), 32'hFF);
        repeat (5) cyc(1'b0, 2'd0, 4'd0);
        cyc(1'b1, 2'd0, 4'd0);
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            cyc(1'b0, 2'd0, 4'd0);
            if (tick_o) cnt++;
        end
        chk("off_ticks", 32'(cnt), 32'd50);
        chk("off_pins", 32'(pins_o), 32'd0);

        cyc(1'b1, 2'd1, 4'd0);
        cnt    = 0;
        saw_ff = 1'b0;
        for (int i = 0; i < 256; i++) begin
            cyc(1'b0, 2'd0, 4'd0);
            if (tick_o) cnt++;
            if (pins_o == 8'hFF) saw_ff = 1'b1;
        end
        chk("count_ticks", 32'(cnt), 32'd256);
        chk("count_saw_ff", 32'(saw_ff), 32'd1);
        chk("count_wrap", 32'(pins_o), 32'd0);

        cyc(1'b1, 2'd1, 4'd0);
        repeat (5) cyc(1'b0, 2'd0, 4'd0);
        chk("pre_collide", 32'(pins_o), 32'h05);
        cyc(1'b1, 2'd3, 4'd1);
        chk("collide_pins", 32'(pins_o), 32'h00);
        chk("collide_tick", 32'(tick_o), 32'd0);
        cyc(1'b0, 2'd0, 4'd0);
        chk("collide_wait", 32'(tick_o), 32'd0);
        cyc(1'b0, 2'd0, 4'd0);
        chk("collide_next", 32'(pins_o), 32'hFF);

        cyc(1'b1, 2'd1, 4'd15);
        repeat (15) cyc(1'b0, 2'd0, 4'd0);
        chk("maxdiv_hold", 32'(pins_o), 32'd0);
        cyc(1'b0, 2'd0, 4'd0);
        chk("maxdiv_tick", 32'(pins_o), 32'd1);

        cyc(1'b1, 2'd2, 4'd0);
        repeat (4) cyc(1'b0, 2'd0, 4'd0);
        chk("walk_at_10", 32'(pins_o), 32'h10);
        #2 rst = 1'b1;
        #1;
        chk("arst_pins", 32'(pins_o), 32'd0);
        chk("arst_mode", 32'(mode_o), 32'd1);
        chk("arst_tick", 32'(tick_o), 32'd0);
        chk("arst_hb", 32'(heartbeat_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (7) cyc(1'b0, 2'd0, 4'd0);
        chk("hb_low7", 32'(heartbeat_o), 32'd0);
        cyc(1'b0, 2'd0, 4'd0);
        chk("hb_high8", 32'(heartbeat_o), 32'd1);
        chk("resume_cnt", 32'(pins_o), 32'd8);
        repeat (5) cyc(1'b0, 2'd0, 4'd0);
        cyc(1'b1, 2'd2, 4'd1);
        repeat (20) cyc(1'b0, 2'd0, 4'd0);

        for (int i = 0; i < 400; i++) begin
            logic          ld;
            logic [1:0]    m;
            logic [DW-1:0] d;
            ld = ($urandom_range(0, 9) == 0);
            m  = 2'($urandom_range(0, 3));
            d  = ($urandom_range(0, 7) == 0) ? 4'd15
                 : 4'($urandom_range(0, 3));
            cyc(ld, m, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
